// File: rtl/hz_pkg.sv
// Shared encodings for the pipeline hazard controller: opcodes, timing codes,
// forward selects and the instruction-class enum.
package hz_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MTHI  = 6'h11;
   localparam logic [5:0] FN_MFLO  = 6'h12;
   localparam logic [5:0] FN_MTLO  = 6'h13;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_DIV   = 6'h1A;
   localparam logic [5:0] FN_DIVU  = 6'h1B;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUBU  = 6'h23;

   // TUSE_NONE exceeds every Tnew, so an unread operand can never raise a stall
   localparam logic [1:0] TUSE_0    = 2'd0;
   localparam logic [1:0] TUSE_1    = 2'd1;
   localparam logic [1:0] TUSE_2    = 2'd2;
   localparam logic [1:0] TUSE_NONE = 2'd3;

   localparam logic [1:0] TNEW_0 = 2'd0;
   localparam logic [1:0] TNEW_1 = 2'd1;
   localparam logic [1:0] TNEW_2 = 2'd2;

   localparam logic [1:0] FWD_NONE = 2'd0;
   localparam logic [1:0] FWD_E    = 2'd1;
   localparam logic [1:0] FWD_M    = 2'd2;
   localparam logic [1:0] FWD_W    = 2'd3;

   typedef enum logic [3:0] {
      IC_NOP, IC_ALU, IC_ORI, IC_LUI, IC_LW, IC_SW, IC_BEQ, IC_J,
      IC_JAL, IC_JR, IC_MULT, IC_DIV, IC_MFHL, IC_MTHL
   } iclass_e;

   function automatic logic is_md(input iclass_e c);
      return (c == IC_MULT) || (c == IC_DIV) || (c == IC_MFHL) || (c == IC_MTHL);
   endfunction

   function automatic logic raw_hit(input logic [4:0] src, input logic [1:0] tuse,
                                    input logic [4:0] dst, input logic [1:0] tnew);
      return (src != 5'd0) && (src == dst) && (tuse < tnew);
   endfunction

   function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic e_ok,
                                          input logic [4:0] dst_e, input logic m_ok,
                                          input logic [4:0] dst_m, input logic [4:0] dst_w);
      if (src == 5'd0)                  return FWD_NONE;
      if (e_ok && (src == dst_e))       return FWD_E;
      if (m_ok && (src == dst_m))       return FWD_M;
      if (src == dst_w)                 return FWD_W;
      return FWD_NONE;
   endfunction

endpackage

// File: rtl/hazard_ctrl_decode.sv
// Per-stage instruction decoder: class, read registers, destination and timing.
// Unread operands report register 0 so they never match a destination.
module hz_decode
   import hz_pkg::*;
(
   input  logic [31:0] ir_i,
   output iclass_e     cls_o,
   output logic [4:0]  rs_o,
   output logic [4:0]  rt_o,
   output logic [4:0]  dst_o,
   output logic [1:0]  tuse_rs_o,
   output logic [1:0]  tuse_rt_o,
   output logic [1:0]  tnew_e_o
);

   logic [5:0] op, fn;
   logic [4:0] rs_f, rt_f, rd_f;
   logic       unused_ok;

   assign op        = ir_i[31:26];
   assign rs_f      = ir_i[25:21];
   assign rt_f      = ir_i[20:16];
   assign rd_f      = ir_i[15:11];
   assign fn        = ir_i[5:0];
   assign unused_ok = ^ir_i[10:6];

   always_comb begin
      cls_o     = IC_NOP;
      dst_o     = 5'd0;
      tuse_rs_o = TUSE_NONE;
      tuse_rt_o = TUSE_NONE;
      tnew_e_o  = TNEW_0;
      case (op)
         OP_RTYPE: begin
            case (fn)
               FN_ADDU, FN_SUBU: begin
                  cls_o = IC_ALU; dst_o = rd_f; tnew_e_o = TNEW_1;
                  tuse_rs_o = TUSE_1; tuse_rt_o = TUSE_1;
               end
               FN_JR: begin
                  cls_o = IC_JR; tuse_rs_o = TUSE_0;
               end
               FN_MULT, FN_MULTU: begin
                  cls_o = IC_MULT; tuse_rs_o = TUSE_1; tuse_rt_o = TUSE_1;
               end
               FN_DIV, FN_DIVU: begin
                  cls_o = IC_DIV; tuse_rs_o = TUSE_1; tuse_rt_o = TUSE_1;
               end
               FN_MFHI, FN_MFLO: begin
                  cls_o = IC_MFHL; dst_o = rd_f; tnew_e_o = TNEW_1;
               end
               FN_MTHI, FN_MTLO: begin
                  cls_o = IC_MTHL; tuse_rs_o = TUSE_1;
               end
               default: ;
            endcase
         end
         OP_ORI: begin
            cls_o = IC_ORI; dst_o = rt_f; tnew_e_o = TNEW_1; tuse_rs_o = TUSE_1;
         end
         OP_LUI: begin
            cls_o = IC_LUI; dst_o = rt_f; tnew_e_o = TNEW_1;
         end
         OP_LW: begin
            cls_o = IC_LW; dst_o = rt_f; tnew_e_o = TNEW_2; tuse_rs_o = TUSE_1;
         end
         OP_SW: begin
            cls_o = IC_SW; tuse_rs_o = TUSE_1; tuse_rt_o = TUSE_2;
         end
         OP_BEQ: begin
            cls_o = IC_BEQ; tuse_rs_o = TUSE_0; tuse_rt_o = TUSE_0;
         end
         OP_J:   cls_o = IC_J;
         OP_JAL: begin
            cls_o = IC_JAL; dst_o = 5'd31;
         end
         default: ;
      endcase
      rs_o = (tuse_rs_o != TUSE_NONE) ? rs_f : 5'd0;
      rt_o = (tuse_rt_o != TUSE_NONE) ? rt_f : 5'd0;
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage MIPS pipeline, with mult/div
// busy sequencing and a saturating stall-cycle counter.
module hazard_ctrl
   import hz_pkg::*;
#(
   parameter int unsigned MULT_CYC = 5,
   parameter int unsigned DIV_CYC  = 10,
   parameter int unsigned CNT_W    = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] ir_d,
   input  logic [31:0] ir_e,
   input  logic [31:0] ir_m,
   input  logic [31:0] ir_w,
   output logic        en_pc,
   output logic        en_d,
   output logic        flush_e,
   output logic [1:0]  fwd_rs_d,
   output logic [1:0]  fwd_rt_d,
   output logic [1:0]  fwd_rs_e,
   output logic [1:0]  fwd_rt_e,
   output logic        fwd_rt_m,
   output logic        md_busy,
   output logic [31:0] stall_count
);

   iclass_e    cls_d, cls_e, cls_m, cls_w;
   logic [4:0] rs_d, rt_d, dst_d, rs_e, rt_e, dst_e, rs_m, rt_m, dst_m, rs_w, rt_w, dst_w;
   logic [1:0] tuse_rs_d, tuse_rt_d, tnew_d;
   logic [1:0] tuse_rs_e, tuse_rt_e, tnew_e;
   logic [1:0] tuse_rs_m, tuse_rt_m, tnew_em;
   logic [1:0] tuse_rs_w, tuse_rt_w, tnew_ew;
   logic [1:0] tnew_m;

   logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
   logic [31:0]      stall_cnt_q, stall_cnt_d;
   logic             stall, stall_raw, md_busy_w;
   logic             unused_ok;

   hz_decode u_dec_d (.ir_i(ir_d), .cls_o(cls_d), .rs_o(rs_d), .rt_o(rt_d), .dst_o(dst_d),
                      .tuse_rs_o(tuse_rs_d), .tuse_rt_o(tuse_rt_d), .tnew_e_o(tnew_d));
   hz_decode u_dec_e (.ir_i(ir_e), .cls_o(cls_e), .rs_o(rs_e), .rt_o(rt_e), .dst_o(dst_e),
                      .tuse_rs_o(tuse_rs_e), .tuse_rt_o(tuse_rt_e), .tnew_e_o(tnew_e));
   hz_decode u_dec_m (.ir_i(ir_m), .cls_o(cls_m), .rs_o(rs_m), .rt_o(rt_m), .dst_o(dst_m),
                      .tuse_rs_o(tuse_rs_m), .tuse_rt_o(tuse_rt_m), .tnew_e_o(tnew_em));
   hz_decode u_dec_w (.ir_i(ir_w), .cls_o(cls_w), .rs_o(rs_w), .rt_o(rt_w), .dst_o(dst_w),
                      .tuse_rs_o(tuse_rs_w), .tuse_rt_o(tuse_rt_w), .tnew_e_o(tnew_ew));

   assign unused_ok = ^{cls_m, cls_w, rs_m, rs_w, rt_w, dst_d, tnew_d, tuse_rs_e, tuse_rt_e,
                        tuse_rs_m, tuse_rt_m, tuse_rs_w, tuse_rt_w, tnew_ew};

   // One stage later, the remaining result latency drops by one (floor 0)
   assign tnew_m = (tnew_em != TNEW_0) ? tnew_em - 2'd1 : TNEW_0;

   always_comb begin
      stall_raw = raw_hit(rs_d, tuse_rs_d, dst_e, tnew_e) | raw_hit(rs_d, tuse_rs_d, dst_m, tnew_m)
                | raw_hit(rt_d, tuse_rt_d, dst_e, tnew_e) | raw_hit(rt_d, tuse_rt_d, dst_m, tnew_m);
      md_busy_w = (md_cnt_q != '0) | (cls_e == IC_MULT) | (cls_e == IC_DIV);
      stall     = stall_raw | (is_md(cls_d) & md_busy_w);
   end

   assign en_pc    = ~stall;
   assign en_d     = ~stall;
   assign flush_e  = stall;
   assign md_busy  = md_busy_w;
   assign fwd_rs_d = fwd_sel(rs_d, tnew_e == TNEW_0, dst_e, tnew_m == TNEW_0, dst_m, dst_w);
   assign fwd_rt_d = fwd_sel(rt_d, tnew_e == TNEW_0, dst_e, tnew_m == TNEW_0, dst_m, dst_w);
   assign fwd_rs_e = fwd_sel(rs_e, 1'b0, dst_e, tnew_m == TNEW_0, dst_m, dst_w);
   assign fwd_rt_e = fwd_sel(rt_e, 1'b0, dst_e, tnew_m == TNEW_0, dst_m, dst_w);
   assign fwd_rt_m = (rt_m != 5'd0) && (rt_m == dst_w);
   assign stall_count = stall_cnt_q;

   always_comb begin
      if (cls_e == IC_MULT)      md_cnt_d = CNT_W'(MULT_CYC);
      else if (cls_e == IC_DIV)  md_cnt_d = CNT_W'(DIV_CYC);
      else if (md_cnt_q != '0)   md_cnt_d = md_cnt_q - CNT_W'(1);
      else                       md_cnt_d = md_cnt_q;
      stall_cnt_d = (stall && (stall_cnt_q != '1)) ? stall_cnt_q + 32'd1 : stall_cnt_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         md_cnt_q    <= '0;
         stall_cnt_q <= '0;
      end else begin
         md_cnt_q    <= md_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

endmodule
